bubble_sort_ctrl: RTL and testbench
===================================

# bubble_sort_ctrl

Stepwise bubble-sort sequencer for the sorting-visualisation designs. It holds a small array filled serially from the random number generator. On `start`, it performs exactly one compare/swap per step, at a pace slow enough for the OLED renderer to animate. The renderer reads array contents through a combinational read port and highlights the active pair using `cmp_idx` and `swap_pulse`.

## Interface
- `N`, 10: number of elements (2..15).
- `W`, 7: element width in bits (matches `random_num`).
- `STEP_DIV`, 625000: clock cycles per compare step (≥1).
- `clk` in 1: system clock (100 MHz board clock).
- `rst` in 1: asynchronous, active-low reset.
- `load_valid` in 1: write `load_data` to the next array slot.
- `load_data` in W: element value.
- `start` in 1: one-cycle pulse that begins sorting.
- `rd_idx` in 4: display read address.
- `rd_data` out W: `nums[rd_idx]`, combinational; 0 if `rd_idx` ≥ N.
- `busy` out 1: sorting in progress.
- `done` out 1: array sorted. Level signal, held until the next load or start.
- `cmp_idx` out 4: index j of the pair (j, j+1) under comparison; 0 when not busy.
- `swap_pulse` out 1: one-cycle pulse when a swap executes.
- `pass_cnt` out 4: completed passes.
- `swap_cnt` out 8: total swaps in the current sort.

## Operation
- FSM states:
  - IDLE: array empty or partially loaded.
  - READY: N elements loaded.
  - SORT: stepping through compares.
  - DONE: sort complete.
- Loading:
  - Accepted in IDLE, READY and DONE.
  - Each `load_valid` writes `nums[load_ptr]` and increments `load_ptr`.
  - On the N-th write, `load_ptr` wraps to 0 and the FSM enters READY.
  - A write from DONE clears `done` and goes to IDLE, unless it is the N-th write.
  - `load_valid` is ignored in SORT.
- `start`:
  - Accepted only in READY or DONE.
  - Ignored in IDLE (incomplete load) and in SORT.
  - On acceptance: j=0, limit=N-1, swapped=0, `pass_cnt`=0, `swap_cnt`=0, pace counter=0, `busy`=1, `done`=0.
- Step (SORT, when the pace counter reaches STEP_DIV-1; the counter then reloads to 0):
  - If `nums[j] > nums[j+1]` (unsigned, strict): swap both elements in the same cycle, set swapped, `swap_cnt`+1, and pulse `swap_pulse`.
  - Equal values never swap.
  - If j+1 < limit: j increments.
  - Otherwise the pass ends and `pass_cnt` increments:
    - If swapped=0 or limit=1: go to DONE (`busy`=0, `done`=1, `cmp_idx`=0).
    - Else: limit decrements, j=0, swapped=0.
- Simultaneous `load_valid` and `start` in READY or DONE: `start` wins and the load is dropped.
- Worst case is N(N-1)/2 steps (45 for N=10), so `swap_cnt` never wraps.

## Timing
- Reset (async assert):
  - All `nums`=0, `load_ptr`=0, state IDLE.
  - `busy`=0, `done`=0, `cmp_idx`=0, `swap_pulse`=0, `pass_cnt`=0, `swap_cnt`=0.
  - Takes effect immediately, including mid-sort.
  - Release is synchronised internally (two-flop deassert).
- `start` sampled at edge t:
  - `busy`=1 after edge t.
  - First compare at edge t+STEP_DIV.
  - Subsequent compares every STEP_DIV cycles.
- Array write, `cmp_idx`, `swap_pulse` and counters all update on the same edge as the step.
- `done` rises and `busy` falls on the edge of the final step.
- `rd_data` reflects writes and swaps the cycle after the edge that made them.

## Configuration
- `BUBBLE_STEP_PACE_EN`:
  - Defined: the pace counter is built and steps occur every STEP_DIV cycles (human-visible animation).
  - Undefined: no pace counter, STEP_DIV is ignored, one step per clock (first compare at edge t+1), for fast simulation and batch sort.

## Test plan
- Load 1..10 ascending, start → 9 steps, `swap_cnt`=0, `pass_cnt`=1, `done`=1, `rd_data` for idx 0..9 = 1..10.
- Load 10..1 descending, start → 45 `swap_pulse`s, `swap_cnt`=45, `pass_cnt`=9, read-back 1..10.
- Load all 7s → no swaps, `done` after 9 steps; `rd_idx`=12 returns 0.
- Load 3 values, pulse `start` → ignored (`busy`=0). Complete the load, start, then pulse `start` again mid-sort → ignored, result unchanged.
- Assert `rst` low during pass 2 of a descending sort → all outputs 0 immediately, array reads 0, state IDLE.
- With macro defined and STEP_DIV=4 → `cmp_idx` advances exactly every 4 cycles. With macro undefined → `cmp_idx` advances every cycle.

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// rtl/bubble_sort_ctrl.sv - stepwise bubble-sort sequencer with serial load and display read port
// Optional BUBBLE_STEP_PACE_EN: pace steps every STEP_DIV cycles instead of every cycle.
module bubble_sort_ctrl #(
  parameter int N        = 10,
  parameter int W        = 7,
  parameter int STEP_DIV = 625000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         start,
  input  logic [3:0]   rd_idx,
  output logic [W-1:0] rd_data,
  output logic         busy,
  output logic         done,
  output logic [3:0]   cmp_idx,
  output logic         swap_pulse,
  output logic [3:0]   pass_cnt,
  output logic [7:0]   swap_cnt
);

  typedef enum logic [1:0] {IDLE, READY, SORT, DONE} state_t;

  state_t       state;
  logic         rs0, rs1;
  logic [W-1:0] nums [N];
  logic [3:0]   load_ptr;
  logic [3:0]   limit;
  logic         swapped;
  logic         step;
  logic [W-1:0] lo_val, hi_val;
  logic         gt;

  // Reset asserts asynchronously but releases two clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs0 <= 1'b0;
      rs1 <= 1'b0;
    end else begin
      rs0 <= 1'b1;
      rs1 <= rs0;
    end
  end

`ifdef BUBBLE_STEP_PACE_EN
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  logic [PW-1:0] pace;
  assign step = (pace == PW'(STEP_DIV - 1));
`else
  // Unpaced: STEP_DIV is at least 1, so every clock is a step.
  assign step = (STEP_DIV != 0);
`endif

  always_comb begin
    lo_val  = nums[cmp_idx];
    hi_val  = nums[cmp_idx + 4'd1];
    gt      = lo_val > hi_val;
    rd_data = '0;
    if (rd_idx < 4'(N)) rd_data = nums[rd_idx];
  end

  always_ff @(posedge clk or negedge rs1) begin
    if (!rs1) begin
      for (int i = 0; i < N; i++) nums[i] <= '0;
      state      <= IDLE;
      load_ptr   <= '0;
      limit      <= '0;
      swapped    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cmp_idx    <= '0;
      swap_pulse <= 1'b0;
      pass_cnt   <= '0;
      swap_cnt   <= '0;
`ifdef BUBBLE_STEP_PACE_EN
      pace       <= '0;
`endif
    end else begin
      swap_pulse <= 1'b0;
      case (state)
        IDLE, READY, DONE: begin
          // start beats a simultaneous load; IDLE means the array is incomplete
          if (start && state != IDLE) begin
            state    <= SORT;
            cmp_idx  <= '0;
            limit    <= 4'(N - 1);
            swapped  <= 1'b0;
            pass_cnt <= '0;
            swap_cnt <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef BUBBLE_STEP_PACE_EN
            pace     <= '0;
`endif
          end else if (load_valid) begin
            nums[load_ptr] <= load_data;
            done           <= 1'b0;
            if (load_ptr == 4'(N - 1)) begin
              load_ptr <= '0;
              state    <= READY;
            end else begin
              load_ptr <= load_ptr + 4'd1;
              state    <= IDLE;
            end
          end
        end
        SORT: begin
`ifdef BUBBLE_STEP_PACE_EN
          pace <= step ? '0 : pace + PW'(1);
`endif
          if (step) begin
            if (gt) begin
              nums[cmp_idx]        <= hi_val;
              nums[cmp_idx + 4'd1] <= lo_val;
              swap_cnt             <= swap_cnt + 8'd1;
              swap_pulse           <= 1'b1;
            end
            if (cmp_idx + 4'd1 < limit) begin
              cmp_idx <= cmp_idx + 4'd1;
              swapped <= swapped | gt;
            end else begin
              pass_cnt <= pass_cnt + 4'd1;
              cmp_idx  <= '0;
              swapped  <= 1'b0;
              if (!(swapped | gt) || limit == 4'd1) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                limit <= limit - 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb/tb_bubble_sort_ctrl.sv - table-driven and randomized checks of bubble_sort_ctrl against a sort model
module tb_bubble_sort_ctrl;
  localparam int N  = 10;
  localparam int W  = 7;
  localparam int SD = 4;
`ifdef BUBBLE_STEP_PACE_EN
  localparam int SP = SD;
`else
  localparam int SP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         start;
  logic [3:0]   rd_idx;
  logic [W-1:0] rd_data;
  logic         busy, done, swap_pulse;
  logic [3:0]   cmp_idx, pass_cnt;
  logic [7:0]   swap_cnt;

  bubble_sort_ctrl #(.N(N), .W(W), .STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .start(start), .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy),
    .done(done), .cmp_idx(cmp_idx), .swap_pulse(swap_pulse),
    .pass_cnt(pass_cnt), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    int             sw;
    int             ps;
    int             st;
  } vec_t;

  vec_t tbl[6];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int e[N]);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  // Swaps = inversions; passes = largest left-displacement + 1 (final clean pass), capped at N-1.
  function automatic void model(input logic [N*W-1:0] a, output int sw, output int ps,
                                output int st, output logic [N*W-1:0] srt);
    int v[N];
    int q[$];
    int k, inv;
    sw = 0; k = 0; st = 0;
    for (int i = 0; i < N; i++) v[i] = int'(a[i*W +: W]);
    for (int i = 0; i < N; i++) begin
      inv = 0;
      for (int j = 0; j < i; j++) if (v[j] > v[i]) inv++;
      sw += inv;
      if (inv > k) k = inv;
    end
    ps = (k + 1 > N - 1) ? N - 1 : k + 1;
    for (int p = 0; p < ps; p++) st += N - 1 - p;
    for (int i = 0; i < N; i++) q.push_back(v[i]);
    q.sort();
    srt = '0;
    for (int i = 0; i < N; i++) srt[i*W +: W] = W'(q[i]);
  endfunction

  task automatic load_part(input logic [N*W-1:0] d, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d[i*W +: W];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_sort(input logic [N*W-1:0] d, input int esw, input int eps, input int est,
                          input bit do_load, input bit poke);
    int sw_m, ps_m, st_m, cnt, pulses;
    logic [3:0] last_c;
    logic [N*W-1:0] srt;
    model(d, sw_m, ps_m, st_m, srt);
    if (do_load) load_part(d, 0, N);
    check("done_clr_on_load", int'(done), 0);
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    cnt = 0; pulses = 0; last_c = 4'd0;
    while (done !== 1'b1 && cnt < 5000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (swap_pulse) pulses++;
      if (cmp_idx !== last_c) begin
        check("step_grid", cnt % SP, 0);
        last_c = cmp_idx;
      end
      if (poke && cnt == 3*SP + 1) begin
        start = 1'b1;
        @(posedge clk);
        cnt++;
        #1 start = 1'b0;
        if (swap_pulse) pulses++;
      end
    end
    check("sort_cycles", cnt, est * SP);
    check("done", int'(done), 1);
    check("busy_end", int'(busy), 0);
    check("cmp_idx_end", int'(cmp_idx), 0);
    check("swap_cnt", int'(swap_cnt), esw);
    check("pass_cnt", int'(pass_cnt), eps);
    check("swap_pulses", pulses, esw);
    for (int i = 0; i < N; i++) begin
      rd_idx = 4'(i);
      #1 check("readback", int'(rd_data), int'(srt[i*W +: W]));
    end
  endtask

  initial begin
    int e[N];
    int sw_m, ps_m, st_m, w;
    logic [N*W-1:0] d, srt;

    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; rd_idx = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmp_idx", int'(cmp_idx), 0);
    check("rst_swap_pulse", int'(swap_pulse), 0);
    check("rst_pass_cnt", int'(pass_cnt), 0);
    check("rst_swap_cnt", int'(swap_cnt), 0);
    check("rst_rd_data", int'(rd_data), 0);
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);

    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};  tbl[0].data = pack(e); tbl[0].sw = 0;  tbl[0].ps = 1; tbl[0].st = 9;
    e = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};  tbl[1].data = pack(e); tbl[1].sw = 45; tbl[1].ps = 9; tbl[1].st = 45;
    e = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};   tbl[2].data = pack(e); tbl[2].sw = 0;  tbl[2].ps = 1; tbl[2].st = 9;
    e = '{2, 1, 3, 4, 5, 6, 7, 8, 9, 10};  tbl[3].data = pack(e); tbl[3].sw = 1;  tbl[3].ps = 2; tbl[3].st = 17;
    e = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9};  tbl[4].data = pack(e); tbl[4].sw = 9;  tbl[4].ps = 2; tbl[4].st = 17;
    e = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 1};  tbl[5].data = pack(e); tbl[5].sw = 9;  tbl[5].ps = 9; tbl[5].st = 45;

    for (int t = 0; t < 6; t++) begin
      run_sort(tbl[t].data, tbl[t].sw, tbl[t].ps, tbl[t].st, 1'b1, 1'b0);
      if (t == 2) begin
        rd_idx = 4'd12;
        #1 check("rd_out_of_range", int'(rd_data), 0);
      end
    end

    // Partial load: start ignored; then finish load and poke start mid-sort.
    for (int i = 0; i < N; i++) e[i] = int'($urandom_range(0, 127));
    d = pack(e);
    load_part(d, 0, 3);
    pulse_start();
    check("start_ignored_partial", int'(busy), 0);
    load_part(d, 3, N);
    model(d, sw_m, ps_m, st_m, srt);
    run_sort(d, sw_m, ps_m, st_m, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        e[i] = (r < 4) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 3));
      d = pack(e);
      model(d, sw_m, ps_m, st_m, srt);
      run_sort(d, sw_m, ps_m, st_m, 1'b1, 1'b0);
    end

    // Reset during pass 2 of a descending sort.
    d = tbl[1].data;
    load_part(d, 0, N);
    pulse_start();
    w = 0;
    while (pass_cnt != 4'd1 && w < 2000) begin
      @(posedge clk);
      #1 w++;
    end
    check("pass2_reached", int'(pass_cnt), 1);
    repeat (2*SP) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_cmp_idx", int'(cmp_idx), 0);
    check("mid_rst_swap_pulse", int'(swap_pulse), 0);
    check("mid_rst_pass_cnt", int'(pass_cnt), 0);
    check("mid_rst_swap_cnt", int'(swap_cnt), 0);
    for (int i = 0; i < N; i++) begin
      rd_idx = 4'(i);
      #1 check("mid_rst_array", int'(rd_data), 0);
    end
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    pulse_start();
    check("start_ignored_after_rst", int'(busy), 0);
    run_sort(d, 45, 9, 45, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
